// File: rtl/char_layout.sv
// char_layout: text-layout stage in front of the Char glyph ROM.
//
// Maps the scan position onto fixed on-screen fields:
//   HR row   : "HR" label (48 px), three HR digits (16 px each)
//   SPO2 row : "SPO2" label (80 px), three SpO2 digits, "%" sign
// Each frame it latches HR/SpO2 and converts them to BCD with a sequential
// double-dabble engine. Display digits are swapped in all at once, so a
// half-converted number is never shown.
//
// Ports:
//   Clk, Rst        pixel clock, synchronous active-high reset
//   Disp_x, Disp_y  current scan column / row (11 bit)
//   Frame_start     one-cycle pulse at start of vertical blank
//   HR_val          heart rate 0..255
//   SPO2_val        SpO2 in %, values above 100 shown as 100
//   Char_n          glyph index to ROM (0-9, 10 '%', 11 HR, 12 SPO2, 127 blank)
//   Char_x, Char_y  1-based column / 0-based row inside the glyph
//   Char_p          combinational pixel bit returned by the ROM
//   Pix_on          registered text pixel (2 clocks after Disp_x/Disp_y)
//   Busy            high while a conversion is in progress
module char_layout #(
    parameter int unsigned HR_X0 = 100,
    parameter int unsigned HR_Y0 = 40,
    parameter int unsigned SP_X0 = 100,
    parameter int unsigned SP_Y0 = 100
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [10:0] Disp_x,
    input  logic [10:0] Disp_y,
    input  logic        Frame_start,
    input  logic [7:0]  HR_val,
    input  logic [6:0]  SPO2_val,
    output logic [6:0]  Char_n,
    output logic [10:0] Char_x,
    output logic [10:0] Char_y,
    input  logic        Char_p,
    output logic        Pix_on,
    output logic        Busy
);

    localparam int unsigned CW  = 11;   // coordinate width
    localparam int unsigned NW  = 7;    // glyph index width
    localparam int unsigned BW  = 8;    // binary shift register width
    localparam int unsigned DW  = 12;   // three BCD nibbles
    localparam int unsigned CNW = 3;    // shift counter width

    localparam logic [NW-1:0] N_PCT   = NW'(10);
    localparam logic [NW-1:0] N_HR    = NW'(11);
    localparam logic [NW-1:0] N_SPO2  = NW'(12);
    localparam logic [NW-1:0] N_BLANK = NW'(127);

    localparam logic [BW-1:0]  SP_MAX   = BW'(100);
    localparam logic [CNW-1:0] CNT_LAST = CNW'(7);

    // Field boundaries, all inclusive, 11-bit unsigned
    localparam logic [CW-1:0] HR_ROW_Y0 = CW'(HR_Y0);
    localparam logic [CW-1:0] HR_ROW_Y1 = CW'(HR_Y0 + 31);
    localparam logic [CW-1:0] HR_LBL_X0 = CW'(HR_X0);
    localparam logic [CW-1:0] HR_LBL_X1 = CW'(HR_X0 + 47);
    localparam logic [CW-1:0] HR_DIG_X0 = CW'(HR_X0 + 48);
    localparam logic [CW-1:0] SP_ROW_Y0 = CW'(SP_Y0);
    localparam logic [CW-1:0] SP_ROW_Y1 = CW'(SP_Y0 + 31);
    localparam logic [CW-1:0] SP_LBL_X0 = CW'(SP_X0);
    localparam logic [CW-1:0] SP_LBL_X1 = CW'(SP_X0 + 79);
    localparam logic [CW-1:0] SP_DIG_X0 = CW'(SP_X0 + 80);
    localparam logic [CW-1:0] SP_PCT_X0 = CW'(SP_X0 + 128);
    localparam logic [CW-1:0] SP_PCT_X1 = CW'(SP_X0 + 143);
    localparam logic [CW-1:0] DIG_PITCH = CW'(16);
    localparam logic [CW-1:0] DIG_LAST  = CW'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV_HR,
        S_CONV_SP,
        S_COMMIT
    } state_t;

    // Index 0 = hundreds, 1 = tens, 2 = ones
    typedef logic [2:0][NW-1:0] glyph3_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CNW-1:0]  r_cnt;
    logic [BW-1:0]   r_hr_sr;
    logic [BW-1:0]   r_sp_sr;
    logic [DW-1:0]   r_bcd;
    logic [DW-1:0]   r_hr_shadow;
    logic [DW-1:0]   r_sp_shadow;
    logic [DW-1:0]   r_disp_hr;
    logic [DW-1:0]   r_disp_sp;
    logic            r_hit;

    logic [BW-1:0]   w_sp_clamped;
    logic            w_bin_msb;
    logic [DW-1:0]   w_bcd_adj;
    logic [DW-1:0]   w_bcd_shift;
    logic            w_cnt_last;
    glyph3_t         w_hr_glyph;
    glyph3_t         w_sp_glyph;
    logic            w_hr_row;
    logic            w_sp_row;
    logic [NW-1:0]   w_n;
    logic [CW-1:0]   w_x;
    logic [CW-1:0]   w_y;
    logic            w_hit;

    // BCD digits to glyph indices with leading-zero blanking
    function automatic glyph3_t f_glyphs(input logic [DW-1:0] bcd);
        glyph3_t g;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = bcd[11:8];
        t = bcd[7:4];
        o = bcd[3:0];
        g[0] = (h == 4'd0) ? N_BLANK : {3'b000, h};
        g[1] = ((h == 4'd0) && (t == 4'd0)) ? N_BLANK : {3'b000, t};
        g[2] = {3'b000, o};
        return g;
    endfunction

    // State register; Busy tracks the state being entered so it equals state != IDLE
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            Busy    <= (w_state_next != S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (Frame_start) w_state_next = S_LOAD;
            S_LOAD:    w_state_next = S_CONV_HR;
            S_CONV_HR: if (w_cnt_last) w_state_next = S_CONV_SP;
            S_CONV_SP: if (w_cnt_last) w_state_next = S_COMMIT;
            S_COMMIT:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign w_cnt_last   = (r_cnt == CNT_LAST);
    assign w_sp_clamped = ({1'b0, SPO2_val} > SP_MAX) ? SP_MAX : {1'b0, SPO2_val};
    assign w_bin_msb    = (r_state == S_CONV_SP) ? r_sp_sr[BW-1] : r_hr_sr[BW-1];

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = {w_bcd_adj[DW-2:0], w_bin_msb};

    // Conversion datapath and digit registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt       <= '0;
            r_hr_sr     <= '0;
            r_sp_sr     <= '0;
            r_bcd       <= '0;
            r_hr_shadow <= '0;
            r_sp_shadow <= '0;
            r_disp_hr   <= '0;
            r_disp_sp   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_hr_sr <= HR_val;
                    r_sp_sr <= w_sp_clamped;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                end
                S_CONV_HR: begin
                    r_hr_sr <= {r_hr_sr[BW-2:0], 1'b0};
                    r_cnt   <= r_cnt + CNW'(1);
                    if (w_cnt_last) begin
                        r_hr_shadow <= w_bcd_shift;
                        r_bcd       <= '0;
                    end else begin
                        r_bcd <= w_bcd_shift;
                    end
                end
                S_CONV_SP: begin
                    r_sp_sr <= {r_sp_sr[BW-2:0], 1'b0};
                    r_cnt   <= r_cnt + CNW'(1);
                    if (w_cnt_last) begin
                        r_sp_shadow <= w_bcd_shift;
                        r_bcd       <= '0;
                    end else begin
                        r_bcd <= w_bcd_shift;
                    end
                end
                S_COMMIT: begin
                    r_disp_hr <= r_hr_shadow;
                    r_disp_sp <= r_sp_shadow;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign w_hr_glyph = f_glyphs(r_disp_hr);
    assign w_sp_glyph = f_glyphs(r_disp_sp);
    assign w_hr_row   = (Disp_y >= HR_ROW_Y0) && (Disp_y <= HR_ROW_Y1);
    assign w_sp_row   = (Disp_y >= SP_ROW_Y0) && (Disp_y <= SP_ROW_Y1);

    // Field decode; HR fields are checked first so they win any overlap
    always_comb begin : field_decode
        logic [CW-1:0] v_lo;
        v_lo  = '0;
        w_n   = N_BLANK;
        w_x   = '0;
        w_y   = '0;
        w_hit = 1'b0;
        if (w_hr_row) begin
            if ((Disp_x >= HR_LBL_X0) && (Disp_x <= HR_LBL_X1)) begin
                w_hit = 1'b1;
                w_n   = N_HR;
                w_x   = Disp_x - HR_LBL_X0 + CW'(1);
                w_y   = Disp_y - HR_ROW_Y0;
            end
            for (int i = 0; i < 3; i++) begin
                v_lo = HR_DIG_X0 + CW'(i) * DIG_PITCH;
                if (!w_hit && (Disp_x >= v_lo) && (Disp_x <= v_lo + DIG_LAST)) begin
                    w_hit = 1'b1;
                    w_n   = w_hr_glyph[2'(i)];
                    w_x   = Disp_x - v_lo + CW'(1);
                    w_y   = Disp_y - HR_ROW_Y0;
                end
            end
        end
        if (!w_hit && w_sp_row) begin
            if ((Disp_x >= SP_LBL_X0) && (Disp_x <= SP_LBL_X1)) begin
                w_hit = 1'b1;
                w_n   = N_SPO2;
                w_x   = Disp_x - SP_LBL_X0 + CW'(1);
                w_y   = Disp_y - SP_ROW_Y0;
            end
            for (int i = 0; i < 3; i++) begin
                v_lo = SP_DIG_X0 + CW'(i) * DIG_PITCH;
                if (!w_hit && (Disp_x >= v_lo) && (Disp_x <= v_lo + DIG_LAST)) begin
                    w_hit = 1'b1;
                    w_n   = w_sp_glyph[2'(i)];
                    w_x   = Disp_x - v_lo + CW'(1);
                    w_y   = Disp_y - SP_ROW_Y0;
                end
            end
            if (!w_hit && (Disp_x >= SP_PCT_X0) && (Disp_x <= SP_PCT_X1)) begin
                w_hit = 1'b1;
                w_n   = N_PCT;
                w_x   = Disp_x - SP_PCT_X0 + CW'(1);
                w_y   = Disp_y - SP_ROW_Y0;
            end
        end
    end

    // Two-stage pixel pipeline: glyph address, then gated ROM bit
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Char_n <= N_BLANK;
            Char_x <= '0;
            Char_y <= '0;
            r_hit  <= 1'b0;
            Pix_on <= 1'b0;
        end else begin
            Char_n <= w_n;
            Char_x <= w_x;
            Char_y <= w_y;
            r_hit  <= w_hit;
            Pix_on <= Char_p & r_hit;
        end
    end

endmodule

// File: tb/tb_char_layout.sv
// Self-checking bench for char_layout: conversion results, leading-zero
// blanking, field geometry, pixel latency, ignored re-trigger and mid-run reset.
module tb_char_layout;

    localparam int HR_X0 = 100;
    localparam int HR_Y0 = 40;
    localparam int SP_X0 = 100;
    localparam int SP_Y0 = 100;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [10:0] Disp_x;
    logic [10:0] Disp_y;
    logic        Frame_start;
    logic [7:0]  HR_val;
    logic [6:0]  SPO2_val;
    logic [6:0]  Char_n;
    logic [10:0] Char_x;
    logic [10:0] Char_y;
    logic        Char_p;
    logic        Pix_on;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    int disp_hr = 0;   // value the display is expected to show
    int disp_sp = 0;
    int got_g[6];      // probed glyphs: HR h,t,o then SpO2 h,t,o

    char_layout #(.HR_X0(HR_X0), .HR_Y0(HR_Y0), .SP_X0(SP_X0), .SP_Y0(SP_Y0)) dut (
        .Clk(Clk), .Rst(Rst), .Disp_x(Disp_x), .Disp_y(Disp_y),
        .Frame_start(Frame_start), .HR_val(HR_val), .SPO2_val(SPO2_val),
        .Char_n(Char_n), .Char_x(Char_x), .Char_y(Char_y), .Char_p(Char_p),
        .Pix_on(Pix_on), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Arbitrary ROM pattern, combinational in the glyph address
    function automatic logic rom_bit(input int n, input int x, input int y);
        return ((n * 5 + x * 3 + y * 7) % 4) != 0;
    endfunction

    assign Char_p = rom_bit(int'(Char_n), int'(Char_x), int'(Char_y));

    // Decimal digit pos (0 hundreds, 1 tens, 2 ones) of v with leading-zero blanking
    function automatic int exp_glyph(input int v, input int pos);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (pos == 0) return (h == 0) ? 127 : h;
        if (pos == 1) return (h == 0 && t == 0) ? 127 : t;
        return o;
    endfunction

    // Screen model: what glyph/coords a scan position should select
    task automatic model_field(input int x, input int y,
                               output int n, output int cx, output int cy, output bit hit);
        int off;
        n = 127; cx = 0; cy = 0; hit = 0;
        if (y >= HR_Y0 && y < HR_Y0 + 32) begin
            off = x - HR_X0;
            if (off >= 0 && off < 48) begin
                n = 11; cx = off + 1; cy = y - HR_Y0; hit = 1;
            end else if (off >= 48 && off < 96) begin
                n = exp_glyph(disp_hr, (off - 48) / 16);
                cx = (off - 48) % 16 + 1; cy = y - HR_Y0; hit = 1;
            end
        end
        if (!hit && y >= SP_Y0 && y < SP_Y0 + 32) begin
            off = x - SP_X0;
            if (off >= 0 && off < 80) begin
                n = 12; cx = off + 1; cy = y - SP_Y0; hit = 1;
            end else if (off >= 80 && off < 128) begin
                n = exp_glyph(disp_sp, (off - 80) / 16);
                cx = (off - 80) % 16 + 1; cy = y - SP_Y0; hit = 1;
            end else if (off >= 128 && off < 144) begin
                n = 10; cx = off - 127; cy = y - SP_Y0; hit = 1;
            end
        end
    endtask

    // All tasks are entered and left 1 time unit after a rising edge
    task automatic probe(input int x, input int y, output int n, output int cx, output int cy);
        Disp_x = 11'(x);
        Disp_y = 11'(y);
        @(posedge Clk); #1;
        n  = int'(Char_n);
        cx = int'(Char_x);
        cy = int'(Char_y);
    endtask

    task automatic probe_digits();
        int n, cx, cy;
        for (int p = 0; p < 3; p++) begin
            probe(HR_X0 + 48 + 16 * p + int'($urandom_range(0, 15)), HR_Y0 + int'($urandom_range(0, 31)), n, cx, cy);
            got_g[p] = n;
            probe(SP_X0 + 80 + 16 * p + int'($urandom_range(0, 15)), SP_Y0 + int'($urandom_range(0, 31)), n, cx, cy);
            got_g[3 + p] = n;
        end
    endtask

    task automatic run_frame(input int hr, input int sp, output int ncyc);
        HR_val = 8'(hr);
        SPO2_val = 7'(sp);
        Frame_start = 1'b1;
        @(posedge Clk); #1;
        Frame_start = 1'b0;
        ncyc = 0;
        while (Busy === 1'b1 && ncyc < 100) begin
            ncyc++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        int n, cx, cy;
        Rst = 1'b1; Frame_start = 1'b1; HR_val = 8'd72; SPO2_val = 7'd98;
        Disp_x = 11'd100; Disp_y = 11'd40;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Busy !== 1'b0 || Char_n !== 7'd127 || Char_x !== 11'd0 || Char_y !== 11'd0 || Pix_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: busy=%b n=%0d x=%0d y=%0d pix=%b, want 0 127 0 0 0",
                     Busy, Char_n, Char_x, Char_y, Pix_on);
        end
        Rst = 1'b0; Frame_start = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_fs_ignored: busy=%b want 0", Busy);
        end
        disp_hr = 0; disp_sp = 0;
        probe_digits();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_g[i] != exp_glyph(0, i % 3)) begin
                errors++;
                $display("FAIL reset_digit%0d: got %0d want %0d", i, got_g[i], exp_glyph(0, i % 3));
            end
        end
    endtask

    task automatic test_conversion();
        int hrs[10];
        int sps[10];
        int ncyc;
        hrs[0] = 72;  sps[0] = 98;
        hrs[1] = 255; sps[1] = 127;
        hrs[2] = 0;   sps[2] = 5;
        hrs[3] = 100; sps[3] = 100;
        hrs[4] = 9;   sps[4] = 101;
        for (int i = 5; i < 10; i++) begin
            hrs[i] = int'($urandom_range(0, 255));
            sps[i] = int'($urandom_range(0, 127));
        end
        for (int k = 0; k < 10; k++) begin
            run_frame(hrs[k], sps[k], ncyc);
            checks++;
            if (ncyc != 18) begin
                errors++;
                $display("FAIL busy_len hr=%0d sp=%0d: got %0d cycles want 18", hrs[k], sps[k], ncyc);
            end
            disp_hr = hrs[k];
            disp_sp = (sps[k] > 100) ? 100 : sps[k];
            probe_digits();
            for (int i = 0; i < 6; i++) begin
                int e;
                e = exp_glyph((i < 3) ? disp_hr : disp_sp, i % 3);
                checks++;
                if (got_g[i] != e) begin
                    errors++;
                    $display("FAIL digit hr=%0d sp=%0d idx=%0d: got %0d want %0d",
                             hrs[k], sps[k], i, got_g[i], e);
                end
            end
        end
    endtask

    task automatic test_geometry();
        int px[8], py[8], en[8], ex[8], ey[8];
        int n, cx, cy;
        px[0] = 100; py[0] = 40;  en[0] = 11;  ex[0] = 1;  ey[0] = 0;
        px[1] = 147; py[1] = 71;  en[1] = 11;  ex[1] = 48; ey[1] = 31;
        px[2] = 148; py[2] = 40;  en[2] = exp_glyph(disp_hr, 0); ex[2] = 1; ey[2] = 0;
        px[3] = 228; py[3] = 100; en[3] = 10;  ex[3] = 1;  ey[3] = 0;
        px[4] = 244; py[4] = 100; en[4] = 127; ex[4] = 0;  ey[4] = 0;
        px[5] = 99;  py[5] = 40;  en[5] = 127; ex[5] = 0;  ey[5] = 0;
        px[6] = 100; py[6] = 72;  en[6] = 127; ex[6] = 0;  ey[6] = 0;
        px[7] = 179; py[7] = 131; en[7] = 12;  ex[7] = 80; ey[7] = 31;
        for (int k = 0; k < 8; k++) begin
            probe(px[k], py[k], n, cx, cy);
            checks++;
            if (n != en[k] || cx != ex[k] || cy != ey[k]) begin
                errors++;
                $display("FAIL geom (%0d,%0d): got n=%0d x=%0d y=%0d want n=%0d x=%0d y=%0d",
                         px[k], py[k], n, cx, cy, en[k], ex[k], ey[k]);
            end
        end
    endtask

    task automatic test_pixel_latency();
        localparam int N = 300;
        int  en[N], ex[N], ey[N];
        bit  eh[N];
        int  x, y;
        for (int j = 0; j < N + 2; j++) begin
            if (j >= 2) begin
                logic want;
                want = eh[j-2] ? rom_bit(en[j-2], ex[j-2], ey[j-2]) : 1'b0;
                checks++;
                if (Pix_on !== want) begin
                    errors++;
                    $display("FAIL pix_on step %0d: got %b want %b", j - 2, Pix_on, want);
                end
            end
            if (j >= 1 && j <= N) begin
                checks++;
                if (int'(Char_n) != en[j-1] || int'(Char_x) != ex[j-1] || int'(Char_y) != ey[j-1]) begin
                    errors++;
                    $display("FAIL char_addr step %0d: got n=%0d x=%0d y=%0d want n=%0d x=%0d y=%0d",
                             j - 1, Char_n, Char_x, Char_y, en[j-1], ex[j-1], ey[j-1]);
                end
            end
            if (j < N) begin
                x = int'($urandom_range(90, 260));
                y = int'($urandom_range(30, 140));
                Disp_x = 11'(x);
                Disp_y = 11'(y);
                model_field(x, y, en[j], ex[j], ey[j], eh[j]);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int ncyc, bad;
        run_frame(20, 50, ncyc);
        disp_hr = 20; disp_sp = 50;
        Disp_x = 11'(HR_X0 + 48 + 32 + 5);
        Disp_y = 11'(HR_Y0 + 10);
        HR_val = 8'd163;
        SPO2_val = 7'd87;
        Frame_start = 1'b1;
        @(posedge Clk); #1;
        Frame_start = 1'b0;
        ncyc = 0;
        bad = 0;
        while (Busy === 1'b1 && ncyc < 100) begin
            if (Char_n !== 7'd0) bad++;
            ncyc++;
            Frame_start = (ncyc == 4);
            if (ncyc == 4) HR_val = 8'd49;
            @(posedge Clk); #1;
        end
        Frame_start = 1'b0;
        checks++;
        if (ncyc != 18) begin
            errors++;
            $display("FAIL retrigger_busy_len: got %0d want 18", ncyc);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL digits_changed_early: %0d samples differed from old ones digit 0", bad);
        end
        @(posedge Clk); #1;
        checks++;
        if (Char_n !== 7'd3) begin
            errors++;
            $display("FAIL ones_after_commit: got %0d want 3", Char_n);
        end
        disp_hr = 163; disp_sp = 87;
        probe_digits();
        for (int i = 0; i < 6; i++) begin
            int e;
            e = exp_glyph((i < 3) ? disp_hr : disp_sp, i % 3);
            checks++;
            if (got_g[i] != e) begin
                errors++;
                $display("FAIL retrigger_digit%0d: got %0d want %0d", i, got_g[i], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ncyc;
        HR_val = 8'd200;
        SPO2_val = 7'd99;
        Frame_start = 1'b1;
        @(posedge Clk); #1;
        Frame_start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_reset: got %b want 0", Busy);
        end
        disp_hr = 0; disp_sp = 0;
        probe_digits();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_g[i] != exp_glyph(0, i % 3)) begin
                errors++;
                $display("FAIL midreset_digit%0d: got %0d want %0d", i, got_g[i], exp_glyph(0, i % 3));
            end
        end
        run_frame(200, 99, ncyc);
        checks++;
        if (ncyc != 18) begin
            errors++;
            $display("FAIL post_reset_busy_len: got %0d want 18", ncyc);
        end
        disp_hr = 200; disp_sp = 99;
        probe_digits();
        for (int i = 0; i < 6; i++) begin
            int e;
            e = exp_glyph((i < 3) ? disp_hr : disp_sp, i % 3);
            checks++;
            if (got_g[i] != e) begin
                errors++;
                $display("FAIL post_reset_digit%0d: got %0d want %0d", i, got_g[i], e);
            end
        end
    endtask

    initial begin
        Rst = 1'b1;
        Frame_start = 1'b0;
        HR_val = '0;
        SPO2_val = '0;
        Disp_x = '0;
        Disp_y = '0;
        #1;
        test_reset();
        test_conversion();
        test_geometry();
        test_pixel_latency();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/char_layout.md
# char_layout

Text-layout stage feeding the `Char` glyph ROM in the display path. It maps the current scan position from the VGA timing generator onto fixed on-screen fields: the HR label, three HR digits, the SPO2 label, three SPO2 digits and a `%` sign. Each frame it latches new HR and SpO2 values and converts them to BCD with a sequential double-dabble engine. It drives `Char_n`/`Char_x`/`Char_y` to the ROM and registers the returned `Char_p` into a pixel-enable output for the colour mux.

## Interface
- `HR_X0`, 100: left x of HR label (48 px wide).
- `HR_Y0`, 40: top y of HR row (32 px high).
- `SP_X0`, 100: left x of SPO2 label (80 px wide).
- `SP_Y0`, 100: top y of SPO2 row.
- `Clk` in 1: pixel clock; single clock domain.
- `Rst` in 1: synchronous, active-high reset.
- `Disp_x` in 11: current scan column.
- `Disp_y` in 11: current scan row.
- `Frame_start` in 1: one-cycle pulse at start of vertical blank.
- `HR_val` in 8: heart rate, 0..255 bpm.
- `SPO2_val` in 7: SpO2 in %. Values >100 are clamped to 100.
- `Char_n` out 7: glyph index to ROM (0-9 digits, 10 `%`, 11 HR, 12 SPO2, 127 blank).
- `Char_x` out 11: 1-based column inside glyph (1..W).
- `Char_y` out 11: 0-based row inside glyph (0..31).
- `Char_p` in 1: combinational pixel bit returned by ROM.
- `Pix_on` out 1: registered text pixel for the colour mux.
- `Busy` out 1: high while BCD conversion runs.

## Operation
- FSM states: IDLE, LOAD, CONV_HR, CONV_SP, COMMIT.
- IDLE: on `Frame_start` go to LOAD. Otherwise stay.
- LOAD, 1 cycle: capture `HR_val` into an 8-bit shift register and `min(SPO2_val,100)` into a second shift register. Clear the 12-bit BCD accumulator.
- CONV_HR, 8 cycles: double dabble. Each cycle, add 3 to any BCD nibble ≥5, then shift `{bcd,bin}` left by 1. After 8 shifts, store the 3 HR digits in a shadow register, clear the accumulator and go to CONV_SP.
- CONV_SP, 8 cycles: same algorithm for the SpO2 value. Store the result in the SpO2 shadow register.
- COMMIT, 1 cycle: copy both shadow registers into the display digit registers simultaneously, then return to IDLE.
- Complete frame update takes 18 cycles (LOAD + 8 + 8 + COMMIT). Display digits change only in COMMIT, so no half-updated number is ever shown.
- `Frame_start` outside IDLE is ignored (no queueing).
- `Busy` = state ≠ IDLE.
- Field decode, with row hit when `Y0 ≤ Disp_y ≤ Y0+31` and `Char_y = Disp_y−Y0`:
  - HR row:
    - `[HR_X0, HR_X0+47]` → n=11, `Char_x = Disp_x−HR_X0+1`.
    - Digit i (i = 0 hundreds, 1 tens, 2 ones) at `[HR_X0+48+16i, +15]` → n=digit, `Char_x = offset+1`.
  - SPO2 row:
    - `[SP_X0, SP_X0+79]` → n=12.
    - Digits at `SP_X0+80+16i`.
    - `%` at `[SP_X0+128, +15]` → n=10.
- Leading-zero blanking, applied to both values: hundreds digit = 0 → n=127. Hundreds and tens both 0 → tens n=127. Ones digit is never blanked.
- Outside every field: `Char_n = 127`, `Char_x = 0`, `Char_y = 0`, field-hit = 0.
- If the parameters make fields overlap, the HR row has priority.
- Field arithmetic is 11-bit unsigned. Compares use explicit `≥`/`≤`, so no subtraction underflow drives selection.

## Timing
- Cycle t: `Disp_x`/`Disp_y` sampled.
- Cycle t+1: `Char_n`/`Char_x`/`Char_y` and the internal hit flag are registered and valid. `Char_p` returns combinationally in the same cycle.
- Cycle t+2: `Pix_on = Char_p & hit` (registered). Pixel latency is 2 clocks; the timing generator delays hsync/vsync/de to match.
- Reset values:
  - FSM state: IDLE.
  - `Busy`: 0.
  - Display digits: 0 (shows "0" with leading zeros blanked).
  - Shadow digits and shift registers: 0.
  - `Char_n`: 127.
  - `Char_x`, `Char_y`: 0.
  - `Pix_on`: 0.
- `Rst` mid-conversion: FSM returns to IDLE, `Busy` falls on the next cycle, and display digits reset to 0. The partial result is discarded.
- `Frame_start` coincident with `Rst`: reset wins and no conversion starts.
- `Frame_start` in the same cycle as COMMIT: ignored, because state ≠ IDLE.

## Test plan
- HR_val=72, SPO2_val=98, pulse `Frame_start`:
  - `Busy` high for exactly 18 cycles.
  - After COMMIT, scanning HR digit 0 gives n=127, digit 1 gives n=7, digit 2 gives n=2.
  - SpO2 digits give 127, 9, 8.
- HR_val=255, SPO2_val=127: HR digits 2,5,5. SpO2 clamped to 1,0,0.
- HR_val=0, SPO2_val=5: HR digits show 127,127,0 and SpO2 digits show 127,127,5. HR_val=100 gives 1,0,0 with no blanking.
- Geometry, default parameters:
  - Disp=(100,40) → n=11, x=1, y=0.
  - (147,71) → n=11, x=48, y=31.
  - (148,40) → HR hundreds digit, x=1.
  - (228,100) → n=10.
  - (244,100) → n=127.
  - (99,40) and (100,72) → n=127.
  - With a ROM model attached, `Pix_on` equals the ROM bit exactly 2 cycles after the coordinate.
- Change HR_val mid-conversion and pulse `Frame_start` again at cycle 5: no restart, result uses the value latched in LOAD, and display digits change only in COMMIT.
- Assert `Rst` at cycle 10 of a conversion: `Busy`=0 next cycle, display digits reset to 0, and a fresh `Frame_start` then completes normally in 18 cycles.
